// File: rtl/ptw_mem_arbiter.sv
// ptw_mem_arbiter: round-robin arbiter sharing one AXI-master read path between ITLB and DTLB page-table walks
//   CLK, RST (async, active-high)      clock and reset
//   TLB_FLUSH                          drops pending requests and the in-flight response
//   REQn_ADDR_VALID / REQn_ADDR        one-cycle PTE read request from TLB n
//   REQn_DATA_VALID / REQn_DATA        one-cycle PTE response strobe and held data to TLB n
//   REQn_ERR                           one-cycle access-fault strobe to TLB n on timeout
//   ADDR_TO_AXIM_VALID / ADDR_TO_AXIM  read address to AXI master, held until AXIM_ADDR_READY
//   DATA_FROM_AXIM_VALID / _AXIM       returned read beat
//   BUSY, OWNER                        walk in progress; port of current or last grant
module ptw_mem_arbiter #(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = $clog2(TIMEOUT_CYCLES) + 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  TLB_FLUSH,
    input  logic                  REQ0_ADDR_VALID,
    input  logic [ADDR_WIDTH-1:0] REQ0_ADDR,
    output logic                  REQ0_DATA_VALID,
    output logic [DATA_WIDTH-1:0] REQ0_DATA,
    output logic                  REQ0_ERR,
    input  logic                  REQ1_ADDR_VALID,
    input  logic [ADDR_WIDTH-1:0] REQ1_ADDR,
    output logic                  REQ1_DATA_VALID,
    output logic [DATA_WIDTH-1:0] REQ1_DATA,
    output logic                  REQ1_ERR,
    output logic                  ADDR_TO_AXIM_VALID,
    output logic [ADDR_WIDTH-1:0] ADDR_TO_AXIM,
    input  logic                  AXIM_ADDR_READY,
    input  logic                  DATA_FROM_AXIM_VALID,
    input  logic [DATA_WIDTH-1:0] DATA_FROM_AXIM,
    output logic                  BUSY,
    output logic                  OWNER
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    state_t state, state_d;
    logic pend0, pend1, rr_ptr, owner, discard;
    logic [ADDR_WIDTH-1:0] addr0, addr1;
    logic [CNT_WIDTH-1:0] cnt;
    logic grant, sel, accept, got, expire, done, keep, cap0, cap1;
    always_comb begin
        state_d = state;
        grant   = 1'b0;
        sel     = 1'b0;
        accept  = 1'b0;
        got     = 1'b0;
        expire  = 1'b0;
        case (state)
            IDLE: begin
                sel = (pend0 && pend1) ? rr_ptr : pend1;
                if ((pend0 || pend1) && !TLB_FLUSH) begin
                    grant   = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                accept  = AXIM_ADDR_READY;
                state_d = AXIM_ADDR_READY ? WAIT : ISSUE;
            end
            WAIT: begin
                got     = DATA_FROM_AXIM_VALID;
                expire  = !DATA_FROM_AXIM_VALID && cnt == CNT_MAX;
                state_d = (got || expire) ? IDLE : WAIT;
            end
            default: state_d = IDLE;
        endcase
    end
    assign done = got || expire;
    // a flush on the completing edge still suppresses that response
    assign keep = !discard && !TLB_FLUSH;
    // the owner may re-request on the very edge its walk completes
    assign cap0 = REQ0_ADDR_VALID && !TLB_FLUSH && !pend0 && !(state != IDLE && !owner && !done);
    assign cap1 = REQ1_ADDR_VALID && !TLB_FLUSH && !pend1 && !(state != IDLE && owner && !done);
    assign BUSY  = state != IDLE;
    assign OWNER = owner;
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_d;
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pend0              <= 1'b0;
            pend1              <= 1'b0;
            addr0              <= '0;
            addr1              <= '0;
            rr_ptr             <= 1'b0;
            owner              <= 1'b0;
            discard            <= 1'b0;
            cnt                <= '0;
            ADDR_TO_AXIM_VALID <= 1'b0;
            ADDR_TO_AXIM       <= '0;
            REQ0_DATA_VALID    <= 1'b0;
            REQ1_DATA_VALID    <= 1'b0;
            REQ0_ERR           <= 1'b0;
            REQ1_ERR           <= 1'b0;
            REQ0_DATA          <= '0;
            REQ1_DATA          <= '0;
        end else begin
            pend0 <= cap0 || (pend0 && !TLB_FLUSH && !(grant && !sel));
            pend1 <= cap1 || (pend1 && !TLB_FLUSH && !(grant && sel));
            if (cap0) addr0 <= REQ0_ADDR;
            if (cap1) addr1 <= REQ1_ADDR;
            if (grant) begin
                owner              <= sel;
                ADDR_TO_AXIM       <= sel ? addr1 : addr0;
                ADDR_TO_AXIM_VALID <= 1'b1;
            end
            if (accept) ADDR_TO_AXIM_VALID <= 1'b0;
            if (accept) cnt <= '0;
            else if (state == WAIT && cnt != CNT_MAX) cnt <= cnt + CNT_WIDTH'(1);
            if (done) rr_ptr <= !owner;
            discard         <= (state_d == IDLE) ? 1'b0 : (discard || TLB_FLUSH);
            REQ0_DATA_VALID <= got && keep && !owner;
            REQ1_DATA_VALID <= got && keep && owner;
            REQ0_ERR        <= expire && keep && !owner;
            REQ1_ERR        <= expire && keep && owner;
            if (got && keep && !owner) REQ0_DATA <= DATA_FROM_AXIM;
            if (got && keep && owner) REQ1_DATA <= DATA_FROM_AXIM;
        end
    end
endmodule

// File: tb/tb_ptw_mem_arbiter.sv
// tb_ptw_mem_arbiter: randomized and directed check of ptw_mem_arbiter against a walk-level reference model
module tb_ptw_mem_arbiter;
    localparam int T = 8;
    logic CLK = 1'b0, RST = 1'b1, TLB_FLUSH = 1'b0;
    logic REQ0_ADDR_VALID = 1'b0, REQ1_ADDR_VALID = 1'b0;
    logic AXIM_ADDR_READY = 1'b0, DATA_FROM_AXIM_VALID = 1'b0;
    logic [63:0] REQ0_ADDR = '0, REQ1_ADDR = '0, DATA_FROM_AXIM = '0;
    logic REQ0_DATA_VALID, REQ1_DATA_VALID, REQ0_ERR, REQ1_ERR;
    logic ADDR_TO_AXIM_VALID, BUSY, OWNER;
    logic [63:0] REQ0_DATA, REQ1_DATA, ADDR_TO_AXIM;

    ptw_mem_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .CLK(CLK), .RST(RST), .TLB_FLUSH(TLB_FLUSH),
        .REQ0_ADDR_VALID(REQ0_ADDR_VALID), .REQ0_ADDR(REQ0_ADDR),
        .REQ0_DATA_VALID(REQ0_DATA_VALID), .REQ0_DATA(REQ0_DATA), .REQ0_ERR(REQ0_ERR),
        .REQ1_ADDR_VALID(REQ1_ADDR_VALID), .REQ1_ADDR(REQ1_ADDR),
        .REQ1_DATA_VALID(REQ1_DATA_VALID), .REQ1_DATA(REQ1_DATA), .REQ1_ERR(REQ1_ERR),
        .ADDR_TO_AXIM_VALID(ADDR_TO_AXIM_VALID), .ADDR_TO_AXIM(ADDR_TO_AXIM),
        .AXIM_ADDR_READY(AXIM_ADDR_READY),
        .DATA_FROM_AXIM_VALID(DATA_FROM_AXIM_VALID), .DATA_FROM_AXIM(DATA_FROM_AXIM),
        .BUSY(BUSY), .OWNER(OWNER)
    );

    always #5 CLK = ~CLK;

    int total = 0, bad = 0;

    // walk-level model: which ports wait, which walk is in flight and how far along it is
    logic [1:0] m_pend, m_dv, m_err;
    logic [63:0] m_addr [2];
    logic [63:0] m_data [2];
    logic m_rr, m_owner, m_drop, m_axv;
    logic [63:0] m_axa;
    int m_phase;   // 0 no walk, 1 address offered, 2 awaiting beat
    int m_waited;  // cycles spent awaiting the beat

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = '0; m_dv = '0; m_err = '0;
        m_addr[0] = '0; m_addr[1] = '0; m_data[0] = '0; m_data[1] = '0;
        m_rr = 0; m_owner = 0; m_drop = 0; m_axv = 0; m_axa = '0;
        m_phase = 0; m_waited = 0;
    endtask

    function automatic logic finishing(input logic dv);
        return m_phase == 2 && (dv || m_waited == T - 1);
    endfunction

    function automatic logic may_request(input int n, input logic dv);
        return !m_pend[n] && !(m_phase != 0 && int'(m_owner) == n && !finishing(dv));
    endfunction

    task automatic model_step(input logic r0, input logic [63:0] a0, input logic r1, input logic [63:0] a1,
                              input logic rdy, input logic dv, input logic [63:0] d, input logic fl);
        logic fin, c0, c1, gnt, p;
        int ph;
        ph  = m_phase;
        fin = finishing(dv);
        c0  = r0 && !fl && may_request(0, dv);
        c1  = r1 && !fl && may_request(1, dv);
        m_dv = '0; m_err = '0; gnt = 0; p = 0;
        if (ph == 0) begin
            if (m_pend != 0 && !fl) begin
                gnt = 1;
                p = (m_pend == 2'b11) ? m_rr : m_pend[1];
                m_owner = p; m_axa = m_addr[p]; m_axv = 1; m_phase = 1;
            end
        end else if (ph == 1) begin
            if (rdy) begin m_axv = 0; m_waited = 0; m_phase = 2; end
        end else if (fin) begin
            if (!(m_drop || fl)) begin
                if (dv) begin m_dv[m_owner] = 1; m_data[m_owner] = d; end
                else m_err[m_owner] = 1;
            end
            m_rr = !m_owner; m_phase = 0; m_drop = 0;
        end else m_waited++;
        if (fl && ph != 0 && !fin) m_drop = 1;
        m_pend[0] = c0 || (m_pend[0] && !fl && !(gnt && !p));
        m_pend[1] = c1 || (m_pend[1] && !fl && !(gnt && p));
        if (c0) m_addr[0] = a0;
        if (c1) m_addr[1] = a1;
    endtask

    task automatic check_all();
        chk("axim_valid", ADDR_TO_AXIM_VALID, m_axv);
        chk("axim_addr", ADDR_TO_AXIM, m_axa);
        chk("busy", BUSY, m_phase != 0);
        chk("owner", OWNER, m_owner);
        chk("req0_dv", REQ0_DATA_VALID, m_dv[0]);
        chk("req1_dv", REQ1_DATA_VALID, m_dv[1]);
        chk("req0_err", REQ0_ERR, m_err[0]);
        chk("req1_err", REQ1_ERR, m_err[1]);
        chk("req0_data", REQ0_DATA, m_data[0]);
        chk("req1_data", REQ1_DATA, m_data[1]);
    endtask

    // drive one cycle of inputs at a falling edge, advance the model, check at the next falling edge
    task automatic step(input logic r0, input logic [63:0] a0, input logic r1, input logic [63:0] a1,
                        input logic rdy, input logic dv, input logic [63:0] d, input logic fl);
        REQ0_ADDR_VALID = r0; REQ0_ADDR = a0;
        REQ1_ADDR_VALID = r1; REQ1_ADDR = a1;
        AXIM_ADDR_READY = rdy; DATA_FROM_AXIM_VALID = dv; DATA_FROM_AXIM = d; TLB_FLUSH = fl;
        model_step(r0, a0, r1, a1, rdy, dv, d, fl);
        @(negedge CLK);
        check_all();
    endtask

    task automatic hold(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(0, '0, 0, '0, rdy, 0, '0, 0);
    endtask

    task automatic beat(input logic [63:0] d);
        step(0, '0, 0, '0, 1, 1, d, 0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge CLK);
        check_all();
        RST = 0;
        // simultaneous requests with the pointer at port 0
        step(1, 64'h100, 1, 64'h200, 1, 0, '0, 0);
        hold(3, 1);
        beat(64'hAAAA_0001);
        hold(3, 1);
        beat(64'hBBBB_0002);
        hold(1, 1);
        // single ITLB walk, then both pending again
        step(1, 64'h8000_1000, 0, '0, 1, 0, '0, 0);
        hold(3, 1);
        beat(64'h0000_0000_2000_04CF);
        hold(1, 1);
        step(1, 64'h110, 1, 64'h210, 1, 0, '0, 0);
        hold(3, 1);
        beat(64'hCCCC_0003);
        hold(3, 1);
        beat(64'hDDDD_0004);
        hold(1, 1);
        // address backpressure
        step(1, 64'h300, 0, '0, 0, 0, '0, 0);
        hold(6, 0);
        hold(2, 1);
        beat(64'hEEEE_0005);
        // timeout, then a late beat that must be dropped
        step(0, '0, 1, 64'h400, 1, 0, '0, 0);
        hold(T + 4, 1);
        beat(64'hDEAD_BEEF);
        hold(1, 1);
        // flush during a DTLB walk with an ITLB request pending
        step(0, '0, 1, 64'h500, 1, 0, '0, 0);
        hold(3, 1);
        step(1, 64'h600, 0, '0, 1, 0, '0, 0);
        step(0, '0, 0, '0, 1, 0, '0, 1);
        beat(64'h1111_2222);
        hold(2, 1);
        step(1, 64'h700, 0, '0, 1, 0, '0, 0);
        hold(3, 1);
        beat(64'h3333_4444);
        hold(1, 1);
        // asynchronous reset while the address is being offered
        step(1, 64'h800, 0, '0, 0, 0, '0, 0);
        hold(2, 0);
        #2 RST = 1;
        #1;
        chk("rst_axim_valid", ADDR_TO_AXIM_VALID, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_strobes", {REQ0_DATA_VALID, REQ1_DATA_VALID, REQ0_ERR, REQ1_ERR}, 0);
        model_reset();
        @(negedge CLK);
        RST = 0;
        step(0, '0, 1, 64'h900, 1, 0, '0, 0);
        hold(3, 1);
        beat(64'h5555_6666);
        hold(1, 1);
        // randomized traffic within the request protocol
        for (int i = 0; i < 2000; i++) begin
            logic fl, rdy, dv, r0, r1;
            logic [63:0] d, a0, a1;
            fl  = $urandom_range(0, 49) == 0;
            rdy = $urandom_range(0, 2) != 0;
            dv  = $urandom_range(0, 4) == 0;
            d   = {$urandom, $urandom};
            a0  = {$urandom, $urandom};
            a1  = {$urandom, $urandom};
            r0  = may_request(0, dv) && $urandom_range(0, 3) == 0;
            r1  = may_request(1, dv) && $urandom_range(0, 3) == 0;
            step(r0, a0, r1, a1, rdy, dv, d, fl);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ptw_mem_arbiter.md
Name: ptw_mem_arbiter

Overview:
- Shares the single AXI-master read path used for page-table walks between the instruction TLB (port 0) and the data TLB (port 1).
- Each TLB issues one-cycle PTE-address pulses and waits for one data beat in return.
- This block latches those pulses and grants one outstanding read at a time, round-robin.
- It holds the address until the master accepts it, routes the returned PTE to the owning TLB, and generates an access-fault pulse on timeout.

Parameters:
ADDR_WIDTH, 64, width of PTE read address
DATA_WIDTH, 64, width of PTE data beat
TIMEOUT_CYCLES, 1024, cycles allowed in WAIT before an error response (must be >= 2)
CNT_WIDTH, logb2(TIMEOUT_CYCLES)+1, width of the timeout counter

Ports:
CLK  in  1  clock; all state updates on the rising edge
RST  in  1  reset, asynchronous, active-high
TLB_FLUSH  in  1  sfence/flush: discards pending requests and the in-flight response
REQ0_ADDR_VALID  in  1  ITLB request pulse (one cycle)
REQ0_ADDR  in  ADDR_WIDTH  ITLB PTE address, sampled with the pulse
REQ0_DATA_VALID  out  1  one-cycle response strobe to ITLB
REQ0_DATA  out  DATA_WIDTH  PTE data to ITLB
REQ0_ERR  out  1  one-cycle access-fault strobe to ITLB
REQ1_ADDR_VALID  in  1  DTLB request pulse
REQ1_ADDR  in  ADDR_WIDTH  DTLB PTE address
REQ1_DATA_VALID  out  1  response strobe to DTLB
REQ1_DATA  out  DATA_WIDTH  PTE data to DTLB
REQ1_ERR  out  1  access-fault strobe to DTLB
ADDR_TO_AXIM_VALID  out  1  read request to AXI master
ADDR_TO_AXIM  out  ADDR_WIDTH  read address to AXI master
AXIM_ADDR_READY  in  1  AXI master accepts the address this cycle
DATA_FROM_AXIM_VALID  in  1  read data beat valid
DATA_FROM_AXIM  in  DATA_WIDTH  read data beat
BUSY  out  1  state != IDLE
OWNER  out  1  port index of the current or last grant

Behaviour:
- Reset (async): state=IDLE; pend0=pend1=0; rr_ptr=0; owner=0; counter=0; every output 0.
- Capture: REQn_ADDR_VALID=1 sets pend_n and latches REQn_ADDR into addr_n on the same edge.
  - A pulse while pend_n=1, or while port n owns the in-flight read, is ignored (protocol violation; bench asserts it never happens).
- States are IDLE, ISSUE and WAIT.
- IDLE:
  - If pend0|pend1, select the pending port. When both are pending, rr_ptr chooses (rr_ptr=0 favours port 0).
  - On the grant: owner<=sel, clear pend_sel, ADDR_TO_AXIM<=addr_sel, ADDR_TO_AXIM_VALID<=1, go to ISSUE.
  - A pulse landing in IDLE at edge t gives ADDR_TO_AXIM_VALID=1 after edge t+1 (2-cycle latency).
- ISSUE:
  - VALID and ADDR stay stable until AXIM_ADDR_READY=1.
  - On that edge: VALID<=0, counter<=0, go to WAIT.
- WAIT:
  - On DATA_FROM_AXIM_VALID: REQ{owner}_DATA<=DATA_FROM_AXIM, REQ{owner}_DATA_VALID<=1 for exactly one cycle, rr_ptr<=~owner, go to IDLE.
  - Otherwise counter increments. When counter==TIMEOUT_CYCLES-1 and data is still absent: REQ{owner}_ERR<=1 for one cycle, rr_ptr<=~owner, go to IDLE.
  - A beat arriving on the same edge as the timeout wins: data is delivered, no ERR.
- A new grant may be issued in the same IDLE cycle the previous response strobe is visible; back-to-back turnaround is 1 IDLE cycle.
- REQn_DATA holds its last value between strobes; only the owner's DATA_VALID or ERR ever pulses. At most one strobe per cycle across all four.
- Stray DATA_FROM_AXIM_VALID in IDLE or ISSUE is dropped; no strobe.
- TLB_FLUSH=1:
  - pend0 and pend1 are cleared.
  - In ISSUE, the request is still held until accepted, because the AXI address handshake cannot be retracted.
  - The matching response (or timeout) completes the state sequence but produces no DATA_VALID or ERR.
  - A discard flag set by the flush is cleared on return to IDLE.
  - A request pulse coinciding with TLB_FLUSH is also discarded.
- A request pulse coinciding with its own response or timeout edge is legal (the owner has already been released) and is captured.
- Counter saturates; it never wraps.

Test Plan:
- Single ITLB read: REQ0 pulse addr 0x8000_1000 at t; READY tied 1; data 0x0000_0000_2000_04CF at t+4 -> AXIM valid at t+2 for 1 cycle with that addr; REQ0_DATA_VALID one cycle at t+5 with data; REQ1 strobes stay 0.
- Simultaneous requests: REQ0 (0x100) and REQ1 (0x200) pulse together, rr_ptr=0 -> 0x100 issued first, response to port 0; then 0x200 issued, response to port 1. Repeat with both pending again -> port 1 is granted first.
- Backpressure: AXIM_ADDR_READY low for 5 cycles -> ADDR_TO_AXIM_VALID stays 1 and the address stays constant for 6 cycles; WAIT is entered only after READY.
- Timeout: TIMEOUT_CYCLES=8, no data returned -> REQ1_ERR pulses exactly 8 cycles after address acceptance; state returns to IDLE; a late beat arriving afterwards is dropped.
- Flush mid-walk: REQ1 in WAIT, REQ0 pending, TLB_FLUSH pulse -> pend0 is cleared; the returned beat gives no REQ1_DATA_VALID; BUSY falls; the next REQ0 pulse is serviced normally.
- Async reset asserted in ISSUE with no clock edge -> ADDR_TO_AXIM_VALID, BUSY and all strobes are 0 immediately; after reset release, a new request completes normally.
